// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB pipeline writes win, long-latency results queue and drain into idle slots.
// Optional starvation guard (forced one-cycle drain with StallPipe) is compiled in with WB_STARVE_GUARD_EN.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   PipeRegWrite,
    input  logic [4:0]             PipeWriteRegister,
    input  logic [31:0]            PipeWriteData,
    input  logic                   LLValid,
    input  logic [4:0]             LLWriteRegister,
    input  logic [31:0]            LLWriteData,
    output logic                   LLReady,
    output logic                   StallPipe,
    output logic                   RFWriteEnable,
    output logic [4:0]             RFWriteRegister,
    output logic [31:0]            RFWriteData,
    output logic [$clog2(DEPTH):0] Pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [4:0]       fifo_reg_q  [DEPTH];
    logic [4:0]       fifo_reg_d  [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [31:0]      fifo_data_d [DEPTH];
    logic [DEPTH-1:0] fifo_vld_q, fifo_vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_reg_q, rf_reg_d;
    logic [31:0]      rf_data_q, rf_data_d;

    logic stall_now;
    logic head_present, head_valid;
    logic pipe_req, ll_take;
    logic grant_pipe, grant_head, bypass;
    logic pop, push;

    assign LLReady         = (count_q < CW'(DEPTH));
    assign Pending         = count_q;
    assign RFWriteEnable   = rf_we_q;
    assign RFWriteRegister = rf_reg_q;
    assign RFWriteData     = rf_data_q;
    assign StallPipe       = stall_now;

    always_comb begin
        fifo_reg_d   = fifo_reg_q;
        fifo_data_d  = fifo_data_q;
        fifo_vld_d   = fifo_vld_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rf_we_d      = 1'b0;
        rf_reg_d     = '0;
        rf_data_d    = '0;
        grant_pipe   = 1'b0;
        grant_head   = 1'b0;
        bypass       = 1'b0;

        head_present = (count_q != '0);
        head_valid   = head_present && fifo_vld_q[rd_ptr_q];
        pipe_req     = PipeRegWrite && (PipeWriteRegister != 5'd0);
        ll_take      = LLValid && LLReady;

        // A forced-drain cycle ignores the pipe entirely; otherwise pipe > queued head > bypass.
        if (stall_now) begin
            grant_head = head_valid;
        end else if (pipe_req) begin
            grant_pipe = 1'b1;
        end else if (head_valid) begin
            grant_head = 1'b1;
        end else if (ll_take && !head_present && (LLWriteRegister != 5'd0)) begin
            bypass = 1'b1;
        end

        pop  = head_present && (grant_head || !head_valid);
        push = ll_take && (LLWriteRegister != 5'd0) && !bypass;

        if (grant_pipe) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = PipeWriteRegister;
            rf_data_d = PipeWriteData;
            for (int i = 0; i < DEPTH; i++) begin
                if (fifo_reg_q[i] == PipeWriteRegister) fifo_vld_d[i] = 1'b0;
            end
        end else if (grant_head) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = fifo_reg_q[rd_ptr_q];
            rf_data_d = fifo_data_q[rd_ptr_q];
        end else if (bypass) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = LLWriteRegister;
            rf_data_d = LLWriteData;
        end

        // The write slot is never occupied when pushing, so the new entry survives a same-cycle kill.
        if (push) begin
            fifo_reg_d[wr_ptr_q]  = LLWriteRegister;
            fifo_data_d[wr_ptr_q] = LLWriteData;
            fifo_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fifo_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_reg_q   <= '0;
            rf_data_q  <= '0;
        end else begin
            fifo_vld_q <= fifo_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_reg_q   <= rf_reg_d;
            rf_data_q  <= rf_data_d;
        end
    end

    always_ff @(posedge Clk) begin
        fifo_reg_q  <= fifo_reg_d;
        fifo_data_q <= fifo_data_d;
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] starve_q, starve_d;
    logic           stall_q, stall_d;

    // Count cycles a valid head waits; on the last allowed one, schedule a single forced drain.
    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (head_valid && !pop) begin
            if (starve_q == SCW'(STARVE_LIMIT - 1)) stall_d = 1'b1;
            else starve_d = starve_q + SCW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign stall_now = stall_q;
`else
    // Without the guard the pipe always wins; the limit only matters when the guard is built in.
    assign stall_now = (STARVE_LIMIT < 0);
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_wb_port_arbiter;
    localparam int DEPTH = 4;
    localparam int SL    = 8;

    logic                   Clk = 1'b0;
    logic                   Reset;
    logic                   PipeRegWrite;
    logic [4:0]             PipeWriteRegister;
    logic [31:0]            PipeWriteData;
    logic                   LLValid;
    logic [4:0]             LLWriteRegister;
    logic [31:0]            LLWriteData;
    logic                   LLReady;
    logic                   StallPipe;
    logic                   RFWriteEnable;
    logic [4:0]             RFWriteRegister;
    logic [31:0]            RFWriteData;
    logic [$clog2(DEPTH):0] Pending;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
        .Clk(Clk), .Reset(Reset),
        .PipeRegWrite(PipeRegWrite), .PipeWriteRegister(PipeWriteRegister), .PipeWriteData(PipeWriteData),
        .LLValid(LLValid), .LLWriteRegister(LLWriteRegister), .LLWriteData(LLWriteData),
        .LLReady(LLReady), .StallPipe(StallPipe),
        .RFWriteEnable(RFWriteEnable), .RFWriteRegister(RFWriteRegister), .RFWriteData(RFWriteData),
        .Pending(Pending)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: the LL holding queue as an SV queue of {reg, data, still-wanted}.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          v;
    } ent_t;

    ent_t        q[$];
    bit          chk_en  = 0;
    bit          m_stall = 0;
    int          m_cnt   = 0;
    bit          m_we    = 0;
    logic [4:0]  m_reg   = '0;
    logic [31:0] m_data  = '0;

    always @(posedge Clk) begin : model
        bit   hp, hv, gp, gh, by, ready, popped, nstall;
        ent_t e;
        chk_en = 1;
        if (Reset) begin
            q.delete();
            m_stall = 0; m_cnt = 0;
            m_we = 0; m_reg = '0; m_data = '0;
        end else begin
            hp    = q.size() > 0;
            hv    = hp && q[0].v;
            ready = q.size() < DEPTH;
            gp    = !m_stall && PipeRegWrite && PipeWriteRegister != 0;
            gh    = !gp && hv;
            by    = !gp && !gh && !m_stall && !hp && LLValid && ready && LLWriteRegister != 0;
            m_we = 0; m_reg = '0; m_data = '0;
            if (gp)      begin m_we = 1; m_reg = PipeWriteRegister; m_data = PipeWriteData; end
            else if (gh) begin m_we = 1; m_reg = q[0].r;            m_data = q[0].d;        end
            else if (by) begin m_we = 1; m_reg = LLWriteRegister;   m_data = LLWriteData;   end
            popped = hp && (gh || !hv);
            if (popped) void'(q.pop_front());
            if (gp) foreach (q[i]) if (q[i].r == PipeWriteRegister) q[i].v = 0;
            if (LLValid && ready && LLWriteRegister != 0 && !by) begin
                e.r = LLWriteRegister; e.d = LLWriteData; e.v = 1;
                q.push_back(e);
            end
            nstall = 0;
`ifdef WB_STARVE_GUARD_EN
            if (hv && !popped) begin
                if (m_cnt == SL - 1) begin nstall = 1; m_cnt = 0; end
                else m_cnt++;
            end else m_cnt = 0;
`endif
            m_stall = nstall;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("cyc_we",      32'(RFWriteEnable),   32'(m_we));
            check("cyc_reg",     32'(RFWriteRegister), 32'(m_reg));
            check("cyc_data",    RFWriteData,          m_data);
            check("cyc_pending", 32'(Pending),         32'(q.size()));
            check("cyc_ready",   32'(LLReady),         32'(q.size() < DEPTH));
            check("cyc_stall",   32'(StallPipe),       32'(m_stall));
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic set_in(input bit pw, input logic [4:0] pr, input logic [31:0] pd,
                          input bit lv, input logic [4:0] lr, input logic [31:0] ld);
        PipeRegWrite = pw; PipeWriteRegister = pr; PipeWriteData = pd;
        LLValid = lv; LLWriteRegister = lr; LLWriteData = ld;
    endtask

    task automatic idle();
        set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        cyc(); cyc();
        Reset = 1'b0;
        cyc();

        check("t1_we",    32'(RFWriteEnable),   0);
        check("t1_reg",   32'(RFWriteRegister), 0);
        check("t1_data",  RFWriteData,          0);
        check("t1_pend",  32'(Pending),         0);
        check("t1_ready", 32'(LLReady),         1);
        check("t1_stall", 32'(StallPipe),       0);

        set_in(1, 5'd5, 32'hA5A5A5A5, 0, 5'd0, 32'h0);
        cyc(); idle();
        check("t2_we",   32'(RFWriteEnable),   1);
        check("t2_reg",  32'(RFWriteRegister), 5);
        check("t2_data", RFWriteData,          32'hA5A5A5A5);
        cyc();
        check("t2_idle_we", 32'(RFWriteEnable), 0);

        set_in(0, 5'd0, 32'h0, 1, 5'd7, 32'h12345678);
        cyc(); idle();
        check("t3_we",   32'(RFWriteEnable),   1);
        check("t3_reg",  32'(RFWriteRegister), 7);
        check("t3_data", RFWriteData,          32'h12345678);
        check("t3_pend", 32'(Pending),         0);

        for (int i = 0; i < 4; i++) begin
            set_in(1, 5'd20, 32'(256 + i), 1, 5'(10 + i), 32'(32'hB0 + i));
            cyc();
        end
        check("t4_full_pend",  32'(Pending), 4);
        check("t4_full_ready", 32'(LLReady), 0);
        set_in(1, 5'd21, 32'h200, 1, 5'd14, 32'hEE);
        cyc();
        check("t4_ignored_pend", 32'(Pending),         4);
        check("t4_pipe_reg",     32'(RFWriteRegister), 21);
        idle();
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t4_drain_we",   32'(RFWriteEnable),   1);
            check("t4_drain_reg",  32'(RFWriteRegister), 32'(10 + i));
            check("t4_drain_data", RFWriteData,          32'(32'hB0 + i));
            check("t4_drain_pend", 32'(Pending),         32'(3 - i));
        end

        set_in(1, 5'd20, 32'h300, 1, 5'd9, 32'h1);
        cyc();
        check("t5_pend", 32'(Pending), 1);
        set_in(1, 5'd9, 32'h2, 0, 5'd0, 32'h0);
        cyc(); idle();
        check("t5_kill_reg",  32'(RFWriteRegister), 9);
        check("t5_kill_data", RFWriteData,          2);
        cyc();
        check("t5_silent_we",   32'(RFWriteEnable), 0);
        check("t5_silent_pend", 32'(Pending),       0);
        cyc();
        check("t5_after_we", 32'(RFWriteEnable), 0);

        set_in(1, 5'd20, 32'h301, 1, 5'd11, 32'h33);
        cyc();
        set_in(1, 5'd11, 32'h44, 1, 5'd11, 32'h55);
        cyc(); idle();
        check("t5b_data", RFWriteData,  32'h44);
        check("t5b_pend", 32'(Pending), 2);
        cyc();
        check("t5b_silent_we", 32'(RFWriteEnable), 0);
        check("t5b_silent_pend", 32'(Pending),     1);
        cyc();
        check("t5b_new_reg",  32'(RFWriteRegister), 11);
        check("t5b_new_data", RFWriteData,          32'h55);

        set_in(1, 5'd20, 32'h400, 1, 5'd12, 32'h66);
        cyc();
        set_in(1, 5'd20, 32'h401, 1, 5'd13, 32'h77);
        cyc();
        check("t6_pend", 32'(Pending), 2);
        Reset = 1'b1;
        cyc();
        check("t6_rst_we",   32'(RFWriteEnable), 0);
        check("t6_rst_pend", 32'(Pending),       0);
        Reset = 1'b0; idle();
        cyc();
        check("t6_post_we", 32'(RFWriteEnable), 0);
        cyc();
        check("t6_post2_we", 32'(RFWriteEnable), 0);

        set_in(1, 5'd0, 32'hDEAD, 0, 5'd0, 32'h0);
        cyc();
        check("t7_pipe0_we", 32'(RFWriteEnable), 0);
        set_in(0, 5'd0, 32'h0, 1, 5'd0, 32'hBEEF);
        cyc();
        check("t7_ll0_we",   32'(RFWriteEnable), 0);
        check("t7_ll0_pend", 32'(Pending),       0);
        set_in(1, 5'd20, 32'h500, 1, 5'd0, 32'hCAFE);
        cyc(); idle();
        check("t7_mix_reg",  32'(RFWriteRegister), 20);
        check("t7_mix_pend", 32'(Pending),         0);
        cyc();
        check("t7_idle_we", 32'(RFWriteEnable), 0);

        set_in(1, 5'd20, 32'h600, 1, 5'd15, 32'h99);
        cyc();
        set_in(1, 5'd20, 32'h601, 0, 5'd0, 32'h0);
`ifdef WB_STARVE_GUARD_EN
        for (int k = 1; k <= SL; k++) begin
            cyc();
            check("t8_stall", 32'(StallPipe), 32'(k == SL));
        end
        cyc();
        check("t8_stall_off", 32'(StallPipe),       0);
        check("t8_drain_we",  32'(RFWriteEnable),   1);
        check("t8_drain_reg", 32'(RFWriteRegister), 15);
        check("t8_drain_pend", 32'(Pending),        0);
        idle();
`else
        for (int k = 1; k <= SL + 2; k++) begin
            cyc();
            check("t8_nostall", 32'(StallPipe), 0);
            check("t8_held",    32'(Pending),   1);
        end
        idle();
        cyc();
        check("t8_drain_reg",  32'(RFWriteRegister), 15);
        check("t8_drain_data", RFWriteData,          32'h99);
`endif
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
